// File: rtl/fcpu_cdb_arbiter_pkg.sv
// Shared widths and the common-data-bus payload type.
// Used by fcpu_cdb_arbiter and its round-robin picker.
package fcpu_cdb_arbiter_pkg;

  localparam int RSV_ID_W = 5;
  localparam int DATA_W   = 32;
  localparam int CDB_W    = RSV_ID_W + DATA_W;

  typedef struct packed {
    logic [RSV_ID_W-1:0] tag;
    logic [DATA_W-1:0]   data;
  } cdb_t;

endpackage

// File: rtl/fcpu_cdb_arbiter_rr_pick.sv
// fcpu_rr_pick: first set request at or after ptr, wrapping.
// Returns a one-hot grant, its index and an any-grant flag.
module fcpu_rr_pick #(
  parameter int N = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [PW-1:0] idx_o,
  output logic          any_o
);

  int j;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr_i) + k;
      if (j >= N) j = j - N;
      if (!any_o && req_i[j[PW-1:0]]) begin
        any_o             = 1'b1;
        gnt_o[j[PW-1:0]]  = 1'b1;
        idx_o             = j[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/fcpu_cdb_arbiter.sv
// Common data bus arbiter: round-robin grant, registered broadcast.
// FCPU_CDB_FIXED_PRIO_EN selects lowest-index priority instead.
module fcpu_cdb_arbiter
  import fcpu_cdb_arbiter_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush,
  input  logic [N_REQ-1:0]                  req_valid,
  input  logic [N_REQ-1:0][RSV_ID_W-1:0]    req_tag,
  input  logic [N_REQ-1:0][DATA_W-1:0]      req_data,
  output logic [N_REQ-1:0]                  req_ready,
  output logic                              cdb_valid,
  output logic [RSV_ID_W-1:0]               cdb_tag,
  output logic [DATA_W-1:0]                 cdb_data
);

  localparam int PW = $clog2(N_REQ);

  cdb_t [N_REQ-1:0] payload;
  logic [N_REQ-1:0] pick_gnt;
  logic [PW-1:0]    pick_idx;
  logic             pick_any;
  logic [PW-1:0]    ptr;
  logic             grant_en;
  logic             any_gnt;

  cdb_t cdb_q, cdb_d;
  logic cdb_valid_q, cdb_valid_d;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      payload[i].tag  = req_tag[i];
      payload[i].data = req_data[i];
    end
  end

  fcpu_rr_pick #(.N(N_REQ)) u_pick (
    .req_i (req_valid),
    .ptr_i (ptr),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  // Reset and flush both suppress the grant outright.
  assign grant_en  = !rst && !flush;
  assign req_ready = grant_en ? pick_gnt : '0;
  assign any_gnt   = grant_en && pick_any;

`ifdef FCPU_CDB_FIXED_PRIO_EN
  assign ptr = '0;
`else
  localparam logic [PW-1:0] LAST = PW'(N_REQ - 1);

  logic [PW-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (any_gnt)
      ptr_d = (pick_idx == LAST) ? '0 : pick_idx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;
`endif

  always_comb begin
    cdb_valid_d = any_gnt;
    cdb_d       = any_gnt ? payload[pick_idx] : cdb_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cdb_valid_q <= 1'b0;
      cdb_q       <= '0;
    end else begin
      cdb_valid_q <= cdb_valid_d;
      cdb_q       <= cdb_d;
    end
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb_tag   = cdb_q.tag;
  assign cdb_data  = cdb_q.data;

endmodule

// File: tb/tb_fcpu_cdb_arbiter.sv
// Bench for fcpu_cdb_arbiter: directed steps plus random traffic
// checked against a scan-based reference model.
module tb_fcpu_cdb_arbiter;

  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic [N-1:0]    req_valid;
  logic [N-1:0][4:0]  req_tag;
  logic [N-1:0][31:0] req_data;
  logic [N-1:0]    req_ready;
  logic            cdb_valid;
  logic [4:0]      cdb_tag;
  logic [31:0]     cdb_data;

  int total = 0;
  int bad   = 0;

  int          ptr_m = 0;
  logic        exp_v = 1'b0;
  logic [4:0]  exp_tag = '0;
  logic [31:0] exp_data = '0;

  always #5 clk = ~clk;

  fcpu_cdb_arbiter #(.N_REQ(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .req_valid (req_valid),
    .req_tag   (req_tag),
    .req_data  (req_data),
    .req_ready (req_ready),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_data  (cdb_data)
  );

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic cycle(input logic [N-1:0] v, input logic fl,
                       input logic r);
    int g;
    logic [N-1:0] eg;
    logic [4:0] t;
    logic [31:0] d;
    req_valid = v;
    flush = fl;
    rst = r;
    #3;
    g = (r || fl) ? -1 : pick(v, ptr_m);
    eg = '0;
    if (g >= 0) eg[g] = 1'b1;
    total++;
    assert (req_ready === eg) else begin
      bad++;
      $error("FAIL ready obs=%b exp=%b", req_ready, eg);
    end
    total++;
    assert (cdb_valid === exp_v) else begin
      bad++;
      $error("FAIL cdb_valid obs=%b exp=%b", cdb_valid, exp_v);
    end
    total++;
    assert (cdb_tag === exp_tag) else begin
      bad++;
      $error("FAIL cdb_tag obs=%0d exp=%0d", cdb_tag, exp_tag);
    end
    total++;
    assert (cdb_data === exp_data) else begin
      bad++;
      $error("FAIL cdb_data obs=%h exp=%h", cdb_data, exp_data);
    end
    t = (g >= 0) ? req_tag[g] : '0;
    d = (g >= 0) ? req_data[g] : '0;
    @(posedge clk);
    if (r) begin
      exp_v = 1'b0;
      exp_tag = '0;
      exp_data = '0;
      ptr_m = 0;
    end else if (g >= 0) begin
      exp_v = 1'b1;
      exp_tag = t;
      exp_data = d;
`ifndef FCPU_CDB_FIXED_PRIO_EN
      ptr_m = (g + 1) % N;
`endif
    end else begin
      exp_v = 1'b0;
    end
    #1;
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    req_valid = '0;
    for (int i = 0; i < N; i++) begin
      req_tag[i] = 5'(i + 1);
      req_data[i] = 32'h1000_0000 + 32'(i);
    end
    @(posedge clk);
    #1;
    cycle(4'b1111, 1'b0, 1'b1);
    cycle(4'b1111, 1'b0, 1'b1);

    req_tag[2] = 5'd9;
    req_data[2] = 32'hDEAD_BEEF;
    cycle(4'b0100, 1'b0, 1'b0);
    cycle(4'b0000, 1'b0, 1'b0);
    total++;
    assert (cdb_valid === 1'b0 && cdb_tag === 5'd9) else begin
      bad++;
      $error("FAIL single obs=%b/%0d exp=0/9", cdb_valid, cdb_tag);
    end
    cycle(4'b0000, 1'b0, 1'b0);

    cycle(4'b0000, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) cycle(4'b1111, 1'b0, 1'b0);
    cycle(4'b0000, 1'b0, 1'b0);

    cycle(4'b0000, 1'b0, 1'b1);
    cycle(4'b0100, 1'b0, 1'b0);
    cycle(4'b0011, 1'b0, 1'b0);
    cycle(4'b0011, 1'b0, 1'b0);
    cycle(4'b0000, 1'b0, 1'b0);

    cycle(4'b0010, 1'b1, 1'b0);
    cycle(4'b0010, 1'b0, 1'b0);
    cycle(4'b0000, 1'b0, 1'b0);

    cycle(4'b1010, 1'b0, 1'b0);
    cycle(4'b1010, 1'b0, 1'b0);
    cycle(4'b1010, 1'b0, 1'b0);

    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < N; i++) begin
        req_tag[i] = 5'($urandom);
        req_data[i] = $urandom;
      end
      cycle(4'($urandom), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 49) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
